// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic sequencer: state codes and ROM enable levels.
package da_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ZLOAD = 3'd1;
    localparam state_t S_PART  = 3'd2;
    localparam state_t S_ACC   = 3'd3;
    localparam state_t S_HOLD  = 3'd4;

    // ROM enables are active-low.
    localparam logic ROM_ON  = 1'b0;
    localparam logic ROM_OFF = 1'b1;

endpackage

// File: rtl/da_step_cnt.sv
// Modulo-MOD step counter with enable, synchronous clear and a terminal-count flag.
module da_step_cnt #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/da_seq_ctrl.sv
// Control sequencer for a bit-serial distributed-arithmetic filter: ROM load, partition
// sweep per bit plane, accumulate/shift, and a held result with output handshake.
module da_seq_ctrl
    import da_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_PART     = 4,
    parameter int COEF_DEPTH = 16,
    parameter int CONT_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          cload,
    input  logic                          out_ready,
    output logic                          ready,
    output logic                          busy,
    output logic                          coef_ok,
    output logic                          load_zreg,
    output logic                          acc_clr,
    output logic                          acc_en,
    output logic                          acc_sub,
    output logic                          shift_en,
    output logic [N_PART-1:0]             part_sel,
    output logic [$clog2(DATA_W)-1:0]     bit_idx,
    output logic [$clog2(COEF_DEPTH)-1:0] rom_addr,
    output logic                          CEN,
    output logic                          WEN,
    output logic                          out_valid,
    output logic                          done
);

    localparam int AW = $clog2(COEF_DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam int PW = (N_PART > 1) ? $clog2(N_PART) : 1;

    state_t          state_q, state_d;
    logic            coef_ok_q, coef_ok_d;
    logic            done_q, done_d;
    logic            in_idle, in_zload, in_part, in_acc, in_hold;
    logic            rom_write;
    logic            addr_wrap, part_last, bit_last;
    logic            bit_clr;
    logic [PW-1:0]   part_cnt;

    assign in_idle  = (state_q == S_IDLE);
    assign in_zload = (state_q == S_ZLOAD);
    assign in_part  = (state_q == S_PART);
    assign in_acc   = (state_q == S_ACC);
    assign in_hold  = (state_q == S_HOLD);

    // A load strobe wins over start, so a write cycle can never launch a run.
    assign rom_write = in_idle && cload;
    assign bit_clr   = !(in_zload || in_part || in_acc || in_hold) || (in_hold && out_ready);

    da_step_cnt #(.MOD(COEF_DEPTH), .W(AW)) u_addr_cnt (
        .clk_i(clk), .rst_ni(resetn), .en_i(rom_write), .clr_i(1'b0),
        .cnt_o(rom_addr), .wrap_o(addr_wrap)
    );

    da_step_cnt #(.MOD(N_PART), .W(PW)) u_part_cnt (
        .clk_i(clk), .rst_ni(resetn), .en_i(in_part), .clr_i(!in_part),
        .cnt_o(part_cnt), .wrap_o(part_last)
    );

    da_step_cnt #(.MOD(DATA_W), .W(BW)) u_bit_cnt (
        .clk_i(clk), .rst_ni(resetn), .en_i(in_acc && !bit_last), .clr_i(bit_clr),
        .cnt_o(bit_idx), .wrap_o(bit_last)
    );

    always_comb begin
        state_d   = S_IDLE;
        coef_ok_d = coef_ok_q || (rom_write && addr_wrap);
        done_d    = in_acc && bit_last;
        case (state_q)
            S_IDLE:  state_d = (!cload && start && coef_ok_q) ? S_ZLOAD : S_IDLE;
            S_ZLOAD: state_d = S_PART;
            S_PART:  state_d = part_last ? S_ACC : S_PART;
            S_ACC:   state_d = bit_last ? S_HOLD : S_PART;
            S_HOLD: begin
                if (!out_ready) begin
                    state_d = S_HOLD;
                end else if ((CONT_MODE != 0) && start) begin
                    state_d = S_ZLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            coef_ok_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            coef_ok_q <= coef_ok_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        part_sel = '0;
        for (int p = 0; p < N_PART; p++) begin
            part_sel[p] = in_part && (part_cnt == PW'(p));
        end
    end

    assign coef_ok   = coef_ok_q;
    assign ready     = in_idle && coef_ok_q && !cload;
    assign busy      = in_zload || in_part || in_acc;
    assign load_zreg = in_zload;
    assign acc_clr   = in_zload;
    assign acc_en    = in_acc;
    assign shift_en  = in_acc;
    assign acc_sub   = in_acc && bit_last;
    assign out_valid = in_hold;
    assign done      = done_q && in_hold;
    assign CEN       = (in_zload || in_part || rom_write) ? ROM_ON : ROM_OFF;
    assign WEN       = rom_write ? ROM_ON : ROM_OFF;

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Scoreboard bench for da_seq_ctrl (DATA_W=4, N_PART=2, COEF_DEPTH=8, CONT_MODE=1):
// stimulus queues per-cycle expected outputs and done times, a negedge monitor compares.
module tb_da_seq_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start = 1'b0;
    logic       cload = 1'b0;
    logic       out_ready = 1'b0;
    logic       ready, busy, coef_ok, load_zreg, acc_clr, acc_en, acc_sub, shift_en;
    logic [1:0] part_sel;
    logic [1:0] bit_idx;
    logic [2:0] rom_addr;
    logic       CEN, WEN, out_valid, done;

    typedef struct {
        string       nm;
        logic [18:0] v;
    } expItem_t;

    expItem_t    expQ[$];
    int          latQ[$];
    int          cycNum = 0;
    int          total = 0;
    int          bad = 0;
    logic [18:0] obs;

    da_seq_ctrl #(.DATA_W(4), .N_PART(2), .COEF_DEPTH(8), .CONT_MODE(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .cload(cload), .out_ready(out_ready),
        .ready(ready), .busy(busy), .coef_ok(coef_ok), .load_zreg(load_zreg),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_sub(acc_sub), .shift_en(shift_en),
        .part_sel(part_sel), .bit_idx(bit_idx), .rom_addr(rom_addr),
        .CEN(CEN), .WEN(WEN), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    assign obs = {ready, busy, coef_ok, load_zreg, acc_clr, acc_en, acc_sub, shift_en,
                  part_sel, bit_idx, rom_addr, CEN, WEN, out_valid, done};

    function automatic logic [18:0] mk(input logic rdy, input logic bsy, input logic cok,
                                       input logic zl, input logic ae, input logic sub,
                                       input logic [1:0] ps, input logic [1:0] bi,
                                       input logic [2:0] ad, input logic cen, input logic wen,
                                       input logic ov, input logic dn);
        return {rdy, bsy, cok, zl, zl, ae, sub, ae, ps, bi, ad, cen, wen, ov, dn};
    endfunction

    task automatic checkOutput(input string nm, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b (rdy,bsy,cok,zl,clr,ae,sub,sh,ps,bi,addr,cen,wen,ov,dn)",
                     nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic r,
                                 input logic [18:0] e, input string nm);
        @(posedge clk);
        #1;
        start     = s;
        cload     = c;
        out_ready = r;
        expQ.push_back('{nm, e});
    endtask

    // Cycles 1..13 of a run: ZLOAD, then per bit plane two PART cycles and one ACC cycle.
    task automatic runBody(input logic [2:0] ad, input logic c);
        applyStimulus(1'b0, c, 1'b0, mk(0, 1, 1, 1, 0, 0, 2'b00, 2'd0, ad, 0, 1, 0, 0), "zload");
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b0, c, 1'b0, mk(0, 1, 1, 0, 0, 0, 2'b01, 2'(b), ad, 0, 1, 0, 0), "part0");
            applyStimulus(1'b0, c, 1'b0, mk(0, 1, 1, 0, 0, 0, 2'b10, 2'(b), ad, 0, 1, 0, 0), "part1");
            applyStimulus(1'b0, c, 1'b0, mk(0, 1, 1, 0, 1, (b == 3), 2'b00, 2'(b), ad, 1, 1, 0, 0), "acc");
        end
    endtask

    task automatic loadRom();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'(k), 0, 0, 0, 0), "load");
        end
        applyStimulus(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "loaded");
    endtask

    always @(negedge clk) begin
        expItem_t it;
        if (expQ.size() != 0) begin
            it = expQ.pop_front();
            checkOutput(it.nm, obs, it.v);
        end
        if (resetn === 1'b1 && done === 1'b1) begin
            total++;
            if (latQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL done_unexpected: got done=1 at cycle %0d required no done", cycNum);
            end else if (latQ[0] != cycNum) begin
                bad++;
                $display("[TB] FAIL done_latency: got cycle %0d required cycle %0d", cycNum, latQ[0]);
                void'(latQ.pop_front());
            end else begin
                void'(latQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout required test end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2 checkOutput("reset_state", obs, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0));
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;

        // Start before any load is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "start_noload");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "noload_idle");

        loadRom();

        // Run 1 with 5 cycles of backpressure.
        applyStimulus(1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "start1");
        latQ.push_back(cycNum + 14);
        runBody(3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd3, 3'd0, 1, 1, 1, 1), "hold_done");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd3, 3'd0, 1, 1, 1, 0), "hold_wait");
        end
        applyStimulus(1'b0, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd3, 3'd0, 1, 1, 1, 0), "hold_accept");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "back_idle");

        // Run 2 with cload held high mid-run, then continuous relaunch into run 3.
        applyStimulus(1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "start2");
        latQ.push_back(cycNum + 14);
        runBody(3'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd3, 3'd0, 1, 1, 1, 1), "hold_relaunch");
        latQ.push_back(cycNum + 14);
        runBody(3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd3, 3'd0, 1, 1, 1, 1), "hold3_accept");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "idle3");

        // Reset during the second PART cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "start4");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 1, 1, 1, 0, 0, 2'b00, 2'd0, 3'd0, 0, 1, 0, 0), "zload4");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 0, 2'b01, 2'd0, 3'd0, 0, 1, 0, 0), "part4");
        @(posedge clk);
        #3 resetn = 1'b0;
        #1 checkOutput("reset_midrun", obs, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0));
        @(negedge clk);
        #1 resetn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "start_after_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 3'd0, 1, 1, 0, 0), "ignored_after_rst");

        loadRom();

        // cload and start together: write happens, start is dropped.
        applyStimulus(1'b1, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd0, 0, 0, 0, 0), "contend");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd1, 1, 1, 0, 0), "contend_after");
        applyStimulus(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'd0, 3'd1, 1, 1, 0, 0), "contend_idle");

        repeat (3) @(posedge clk);
        total++;
        if (latQ.size() != 0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending: got %0d done / %0d vectors outstanding required 0",
                     latQ.size(), expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
